// File: rtl/mult_arbiter_if.sv
// Handshake bundle between two requesters, the response consumer and mult_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface mult_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_p;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end sharing one 8x8 signed Wallace multiplier.
// One operation in flight at a time: IDLE -> MUL (settle) -> RESP (hold until taken).

module wallace (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  function automatic logic [15:0] csa_s(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] a_ext;
  logic [15:0] l0 [9];
  logic [15:0] l1 [6];
  logic [15:0] l2 [4];
  logic [15:0] l3 [3];
  logic [15:0] l4 [2];

  assign a_ext = {{8{a_i[7]}}, a_i};

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_pp
      assign l0[gi] = b_i[gi] ? (a_ext << gi) : 16'd0;
    end
  endgenerate

  // b[7] carries weight -128: add (~a << 7) and the +1<<7 that completes the negation
  assign l0[7] = b_i[7] ? ((~a_ext) << 7) : 16'd0;
  assign l0[8] = {8'd0, b_i[7], 7'd0};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_l1
      assign l1[2*gi]   = csa_s(l0[3*gi], l0[3*gi+1], l0[3*gi+2]);
      assign l1[2*gi+1] = csa_c(l0[3*gi], l0[3*gi+1], l0[3*gi+2]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_l2
      assign l2[2*gi]   = csa_s(l1[3*gi], l1[3*gi+1], l1[3*gi+2]);
      assign l2[2*gi+1] = csa_c(l1[3*gi], l1[3*gi+1], l1[3*gi+2]);
    end
  endgenerate

  assign l3[0] = csa_s(l2[0], l2[1], l2[2]);
  assign l3[1] = csa_c(l2[0], l2[1], l2[2]);
  assign l3[2] = l2[3];
  assign l4[0] = csa_s(l3[0], l3[1], l3[2]);
  assign l4[1] = csa_c(l3[0], l3[1], l3[2]);
  assign p_o   = l4[0] + l4[1];
endmodule

module mult_arbiter #(
  parameter int unsigned MUL_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  mult_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [15:0] rsp_p_q, rsp_p_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        last_id_q, last_id_d;
  logic [15:0] mul_p;
  logic        grant_id;
  logic        ready0;
  logic        ready1;

  wallace u_wallace (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  // Readys are gated by rst_n so nothing can be accepted while reset is held
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_id_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
    ready0 = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_id;
    ready1 = rst_n && (state_q == IDLE) && bus.req1_valid && grant_id;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    last_id_d   = last_id_q;
    case (state_q)
      IDLE: begin
        if (ready0 || ready1) begin
          op_a_d    = grant_id ? bus.req1_a : bus.req0_a;
          op_b_d    = grant_id ? bus.req1_b : bus.req0_b;
          rsp_id_d  = grant_id;
          last_id_d = grant_id;
          cnt_d     = CNT_LOAD;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (cnt_q == 4'd0) begin
          rsp_p_d     = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_a_q      <= 8'd0;
      op_b_q      <= 8'd0;
      rsp_p_q     <= 16'd0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      last_id_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      last_id_q   <= last_id_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_p      = rsp_p_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 1, the number of settle cycles allowed for the combinational multiplier; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 has an operation.
REQ-005 SHALL have port req0_ready, output, 1, requester 0 operation accepted this cycle.
REQ-006 SHALL have ports req0_a and req0_b, input, 8 each, requester 0 two's-complement operands.
REQ-007 SHALL have ports req1_valid (input, 1), req1_ready (output, 1), req1_a and req1_b (input, 8 each), with the same meanings for requester 1.
REQ-008 SHALL have port rsp_valid, output, 1, a result is presented.
REQ-009 SHALL have port rsp_ready, input, 1, the consumer takes the result.
REQ-010 SHALL have port rsp_id, output, 1, the index of the requester that owns the result.
REQ-011 SHALL have port rsp_p, output, 16, the signed product.
REQ-012 SHALL have port busy, output, 1, high when state is not IDLE.

Function
REQ-013 SHALL contain exactly one instance of the team's 8x8 signed Wallace multiplier (module wallace), fed only from internal operand registers op_a and op_b.
REQ-014 SHALL implement the FSM states IDLE, MUL and RESP.
REQ-015 SHALL arbitrate in IDLE: the grant goes to the only valid requester; if both are valid, it goes to the requester not granted last (round-robin pointer last_id).
REQ-016 SHALL drive reqN_ready combinationally high only in IDLE, only for the granted requester, and only while that requester's valid is high; at most one ready is high per cycle.
REQ-017 SHALL, on a handshake (valid and ready high at the edge), capture the operands into op_a/op_b, capture the requester index into rsp_id and last_id, load the settle counter with MUL_CYCLES-1, and go to MUL.
REQ-018 SHALL, in MUL, decrement the counter each cycle; on the cycle the counter equals 0, register the multiplier output into rsp_p, set rsp_valid, and go to RESP.
REQ-019 SHALL produce a product equal to the exact two's-complement product signed(a)*signed(b), 16 bits wide, with no saturation or truncation.
REQ-020 SHALL give the latency as follows: for a handshake at edge k, rsp_valid is high from edge k+MUL_CYCLES onward.
REQ-021 SHALL, in RESP, hold rsp_valid, rsp_p and rsp_id stable until rsp_ready is sampled high; on that edge it clears rsp_valid and goes to IDLE.
REQ-022 SHALL, with rsp_ready tied high, accept at most one operation every MUL_CYCLES+2 cycles.
REQ-023 SHALL not accept a new request in the same cycle as a response handshake; no overlap is permitted.
REQ-024 SHALL treat a requester deasserting valid before its handshake as legal; there is no effect and the pointer is not updated.
REQ-025 SHALL leave last_id unchanged on cycles with no grant.
REQ-026 SHALL not change state or any output when request inputs change during MUL or RESP.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously force: state=IDLE, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0, counter=0, op_a=op_b=0, last_id=1 (so requester 0 wins the first tie).
REQ-028 SHALL discard any in-flight operation on reset during MUL or RESP; no response for it appears after reset release.
REQ-029 SHALL hold both ready outputs low while rst_n is low.

Verification
REQ-030 SHALL be covered by this scenario: with MUL_CYCLES=1, req0 a=0x80, b=0x80, rsp_ready=1 -> rsp_valid one edge after the handshake, rsp_p=0x4000, rsp_id=0.
REQ-031 SHALL be covered by this scenario: req1 a=0x7F, b=0x80 -> rsp_p=0xC080, rsp_id=1; then a=0xFF, b=0x01 -> rsp_p=0xFFFF.
REQ-032 SHALL be covered by this scenario: both requesters valid continuously after reset -> grant order 0,1,0,1, with rsp_id alternating to match.
REQ-033 SHALL be covered by this scenario: rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_p and rsp_id unchanged, both readys low, busy=1; rsp_ready=1 -> IDLE on the next edge.
REQ-034 SHALL be covered by this scenario: with MUL_CYCLES=4, rst_n pulsed low during the 2nd MUL cycle -> all outputs 0 at once, no rsp_valid afterwards, and the next tie is granted to requester 0.
REQ-035 SHALL be covered by this scenario: random 2000-operation run with random valid/rsp_ready -> every rsp_p equals the reference signed product, and per-requester ordering and count are preserved.
